slice_serial_comparator: RTL and testbench

Parametrised magnitude comparator that resolves two WIDTH-bit operands one SLICE-bit slice per clock, scanning from the most significant slice down. It terminates early on the first differing slice. It supports unsigned and two's-complement signed operands under a per-transaction mode bit, and takes cascade inputs that decide the result when all slices are equal. It sits between operand producers and consumers with valid/ready handshakes on both sides, and replaces fixed-width cascaded combinational comparators where width, area, or timing closure makes a full-width compare undesirable.

---
 rtl/slice_serial_comparator_if.sv | 36 +++
 rtl/slice_serial_comparator.sv | 129 ++++++++++++
 tb/tb_slice_serial_comparator.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/slice_serial_comparator_if.sv
// Handshake/operand bundle for slice_serial_comparator.
//   master : producer/consumer side (drives requests, out_ready)
//   slave  : comparator side (drives in_ready, out_valid, results)
// Signals:
//   in_valid/in_ready             request handshake
//   a_ip, b_ip, signed_mode       operands and compare mode
//   a_ip_G, b_ip_G, a_ip_E_b      cascade inputs from a less-significant stage
//   out_valid/out_ready           result handshake
//   a_op_G, a_op_E_b, b_op_G      one-hot result (A>B, A==B, B>A)
interface slice_serial_comparator_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_ip;
  logic [WIDTH-1:0] b_ip;
  logic             signed_mode;
  logic             a_ip_G;
  logic             b_ip_G;
  logic             a_ip_E_b;
  logic             out_valid;
  logic             out_ready;
  logic             a_op_G;
  logic             a_op_E_b;
  logic             b_op_G;

  modport master (
    output in_valid, a_ip, b_ip, signed_mode, a_ip_G, b_ip_G, a_ip_E_b, out_ready,
    input  in_ready, out_valid, a_op_G, a_op_E_b, b_op_G
  );

  modport slave (
    input  in_valid, a_ip, b_ip, signed_mode, a_ip_G, b_ip_G, a_ip_E_b, out_ready,
    output in_ready, out_valid, a_op_G, a_op_E_b, b_op_G
  );
endinterface

// File: rtl/slice_serial_comparator.sv
// Serial magnitude comparator: resolves two WIDTH-bit operands SLICE bits per
// clock from the most significant slice down, stopping at the first differing
// slice. Signed operands are mapped to offset binary at capture so the scan
// itself is always unsigned. When every slice is equal the captured cascade
// inputs decide (a_ip_G, then b_ip_G, else equal).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slice_serial_comparator_if.slave (handshakes, operands, results)
module slice_serial_comparator #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  slice_serial_comparator_if.slave    bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   a_reg, a_next;
  logic [WIDTH-1:0]   b_reg, b_next;
  logic               cas_g_reg, cas_g_next;
  logic               cas_l_reg, cas_l_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic               gt_reg, gt_next;
  logic               eq_reg, eq_next;
  logic               lt_reg, lt_next;

  // Captured operands viewed as an array of slices so the active one can be
  // picked by the index counter.
  logic [SLICE-1:0]   a_sl [NSLICE];
  logic [SLICE-1:0]   b_sl [NSLICE];

  genvar gi;
  generate
    for (gi = 0; gi < NSLICE; gi++) begin : g_slice
      assign a_sl[gi] = a_reg[gi*SLICE +: SLICE];
      assign b_sl[gi] = b_reg[gi*SLICE +: SLICE];
    end
  endgenerate

  logic [SLICE-1:0]   a_cur, b_cur;
  assign a_cur = a_sl[idx_reg];
  assign b_cur = b_sl[idx_reg];

  // Inverting the sign bit turns two's complement into offset binary.
  logic [WIDTH-1:0]   sign_flip;
  assign sign_flip = {bus.signed_mode, {(WIDTH-1){1'b0}}};

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    cas_g_next = cas_g_reg;
    cas_l_next = cas_l_reg;
    idx_next   = idx_reg;
    gt_next    = gt_reg;
    eq_next    = eq_reg;
    lt_next    = lt_reg;

    unique case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          a_next     = bus.a_ip ^ sign_flip;
          b_next     = bus.b_ip ^ sign_flip;
          cas_g_next = bus.a_ip_G;
          cas_l_next = bus.b_ip_G;
          idx_next   = IDX_W'(NSLICE - 1);
          state_next = RUN;
        end
      end
      RUN: begin
        if (a_cur > b_cur) begin
          {gt_next, eq_next, lt_next} = 3'b100;
          state_next = DONE;
        end else if (a_cur < b_cur) begin
          {gt_next, eq_next, lt_next} = 3'b001;
          state_next = DONE;
        end else if (idx_reg == '0) begin
          // All slices equal: cascade decides, a_ip_G has priority.
          if (cas_g_reg)      {gt_next, eq_next, lt_next} = 3'b100;
          else if (cas_l_reg) {gt_next, eq_next, lt_next} = 3'b001;
          else                {gt_next, eq_next, lt_next} = 3'b010;
          state_next = DONE;
        end else begin
          idx_next = idx_reg - 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      cas_g_reg <= 1'b0;
      cas_l_reg <= 1'b0;
      idx_reg   <= '0;
      gt_reg    <= 1'b0;
      eq_reg    <= 1'b0;
      lt_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      cas_g_reg <= cas_g_next;
      cas_l_reg <= cas_l_next;
      idx_reg   <= idx_next;
      gt_reg    <= gt_next;
      eq_reg    <= eq_next;
      lt_reg    <= lt_next;
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.a_op_G    = gt_reg;
  assign bus.a_op_E_b  = eq_reg;
  assign bus.b_op_G    = lt_reg;
endmodule

// File: tb/tb_slice_serial_comparator.sv
module tb_slice_serial_comparator;
  localparam int WIDTH = 16;
  localparam int SLICE = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  slice_serial_comparator_if #(.WIDTH(WIDTH)) bus ();

  slice_serial_comparator #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // res is {a_op_G, a_op_E_b, b_op_G}
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sm;
    logic        ag;
    logic        bg;
    logic        ae;
    logic [2:0]  res;
    int          lat;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] res_now();
    return {bus.a_op_G, bus.a_op_E_b, bus.b_op_G};
  endfunction

  // Accept one request and wait (bounded) for out_valid; leaves DUT in DONE.
  task automatic start_txn(input vec_t v);
    int cyc;
    @(negedge clk);
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.a_ip        = v.a;
    bus.b_ip        = v.b;
    bus.signed_mode = v.sm;
    bus.a_ip_G      = v.ag;
    bus.b_ip_G      = v.bg;
    bus.a_ip_E_b    = v.ae;
    bus.in_valid    = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    // Scrambled inputs after capture must not matter.
    bus.a_ip   = ~v.a;
    bus.b_ip   = ~v.b;
    bus.a_ip_G = ~v.ag;
    bus.b_ip_G = ~v.bg;
    chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
    cyc = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (bus.out_valid) break;
    end
    chk("latency", 32'(cyc), 32'(v.lat));
    chk("result", 32'(res_now()), 32'(v.res));
    $display("txn a=%h b=%h sm=%0d cas=%0d%0d%0d res=%03b lat=%0d", v.a, v.b, v.sm,
             v.ag, v.bg, v.ae, res_now(), cyc);
  endtask

  task automatic finish_txn(input logic [2:0] exp_res);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("out_valid_after_hs", 32'(bus.out_valid), 32'd0);
    chk("in_ready_after_hs", 32'(bus.in_ready), 32'd1);
    chk("result_retained", 32'(res_now()), 32'(exp_res));
  endtask

  initial begin
    vec_t v;
    checks = 0;
    errors = 0;
    //        a        b        sm    ag    bg    ae    res     lat
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 1};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 1};
    vecs[2] = '{16'h1234, 16'h1235, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 4};
    vecs[3] = '{16'h1244, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 3};
    vecs[4] = '{16'hABCD, 16'hABCD, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 4};
    vecs[5] = '{16'hABCD, 16'hABCD, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 4};
    vecs[6] = '{16'hABCD, 16'hABCD, 1'b0, 1'b1, 1'b1, 1'b0, 3'b100, 4};
    vecs[7] = '{16'hABCD, 16'hABCD, 1'b1, 1'b0, 1'b1, 1'b1, 3'b001, 4};
    vecs[8] = '{16'hFFFF, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0, 3'b100, 4};
    vecs[9] = '{16'h0100, 16'h0200, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 2};

    bus.in_valid    = 1'b0;
    bus.a_ip        = '0;
    bus.b_ip        = '0;
    bus.signed_mode = 1'b0;
    bus.a_ip_G      = 1'b0;
    bus.b_ip_G      = 1'b0;
    bus.a_ip_E_b    = 1'b0;
    bus.out_ready   = 1'b0;
    rst_n           = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", 32'(res_now()), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      start_txn(vecs[i]);
      finish_txn(vecs[i].res);
    end

    // Stall in DONE: result must hold, nothing gets captured.
    start_txn(vecs[9]);
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = ~bus.in_valid;
      bus.a_ip     = 16'(k * 16'h1111);
      bus.b_ip     = 16'hFFFF;
      @(negedge clk);
      chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_result", 32'(res_now()), 32'b001);
    end
    bus.in_valid = 1'b0;
    finish_txn(3'b001);
    @(negedge clk);
    chk("idle_no_capture", 32'(bus.in_ready), 32'd1);
    $display("txn stall: released, result held %03b", res_now());

    // Abort mid-RUN at idx=2 with an asynchronous reset.
    v = '{16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 4};
    @(negedge clk);
    bus.a_ip = v.a; bus.b_ip = v.b; bus.signed_mode = v.sm;
    bus.a_ip_G = v.ag; bus.b_ip_G = v.bg; bus.a_ip_E_b = v.ae;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("pre_abort_busy", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_result", 32'(res_now()), 32'd0);
    $display("txn abort: reset during RUN");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_abort_idle", 32'(bus.out_valid), 32'd0);

    v = '{16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 1};
    start_txn(v);
    finish_txn(v.res);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
